// File: rtl/rgb_pwm_fader.sv
// Three-channel LED PWM generator with a target interface that either snaps
// the duties at the next PWM period boundary or ramps them one count per fade step.
module rgb_pwm_fader #(
   parameter int CLK_DIV  = 188,
   parameter int FADE_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tgt_valid,
   output logic       tgt_ready,
   input  logic [7:0] tgt_r,
   input  logic [7:0] tgt_g,
   input  logic [7:0] tgt_b,
   input  logic       fade_en,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b,
   output logic       busy,
   output logic [1:0] dbg_state
);

   // Handshake: a target triple transfers on any rising edge where tgt_valid
   // and tgt_ready are both 1; tgt_ready depends only on registered state, and
   // tgt_valid seen while tgt_ready is 0 has no effect.

   localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_DIV - 1);
   localparam logic [FADE_W-1:0] FADE_MAX = FADE_W'(FADE_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SNAP = 2'd1,
      ST_FADE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [PRE_W-1:0]  prescaler;
   logic [7:0]        pwm_cnt;
   logic              tick;
   logic              boundary;

   logic [FADE_W-1:0] fade_cnt;
   logic              fade_due;
   logic              fade_step;

   logic [7:0]        goal_r, goal_g, goal_b;
   logic [7:0]        duty_r, duty_g, duty_b;
   logic [7:0]        step_r, step_g, step_b;
   logic              all_done;

   logic              accept;
   logic              snap_load;
   logic              step_load;

   // Timebase free-runs regardless of the transfer FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= 8'd0;
      end else if (tick) begin
         pwm_cnt <= pwm_cnt + 8'd1;
      end
   end

   assign tick     = (prescaler == PRE_MAX);
   assign boundary = tick && (pwm_cnt == 8'hFF);

   // One-count move toward the goal; strict compare keeps the 8-bit duty from wrapping.
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] goal);
      logic [7:0] res;
      res = cur;
      if (cur < goal) begin
         res = cur + 8'd1;
      end else if (cur > goal) begin
         res = cur - 8'd1;
      end
      return res;
   endfunction

   assign step_r    = step_toward(duty_r, goal_r);
   assign step_g    = step_toward(duty_g, goal_g);
   assign step_b    = step_toward(duty_b, goal_b);
   assign all_done  = (step_r == goal_r) && (step_g == goal_g) && (step_b == goal_b);
   assign fade_due  = (fade_cnt == FADE_MAX);
   assign fade_step = (state == ST_FADE) && boundary && fade_due;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (tgt_valid) begin
               state_nxt = fade_en ? ST_FADE : ST_SNAP;
            end
         end
         ST_SNAP: begin
            if (boundary) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_FADE: begin
            if (fade_step && all_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM: outputs and datapath strobes
   always_comb begin
      tgt_ready = 1'b0;
      accept    = 1'b0;
      snap_load = 1'b0;
      step_load = 1'b0;
      case (state)
         ST_IDLE: begin
            tgt_ready = 1'b1;
            accept    = tgt_valid;
         end
         ST_SNAP: snap_load = boundary;
         ST_FADE: step_load = fade_step;
         default: tgt_ready = 1'b0;
      endcase
      busy      = !tgt_ready;
      dbg_state = state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         goal_r <= 8'd0;
         goal_g <= 8'd0;
         goal_b <= 8'd0;
      end else if (accept) begin
         goal_r <= tgt_r;
         goal_g <= tgt_g;
         goal_b <= tgt_b;
      end
   end

   // Counts period boundaries while fading; a new accept restarts the fade cadence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fade_cnt <= '0;
      end else if (accept) begin
         fade_cnt <= '0;
      end else if ((state == ST_FADE) && boundary) begin
         fade_cnt <= fade_due ? '0 : fade_cnt + 1'b1;
      end
   end

   // Duties only move on a period boundary so every period runs whole.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_r <= 8'd0;
         duty_g <= 8'd0;
         duty_b <= 8'd0;
      end else if (snap_load) begin
         duty_r <= goal_r;
         duty_g <= goal_g;
         duty_b <= goal_b;
      end else if (step_load) begin
         duty_r <= step_r;
         duty_g <= step_g;
         duty_b <= step_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_r <= 1'b0;
         pwm_g <= 1'b0;
         pwm_b <= 1'b0;
      end else begin
         pwm_r <= (pwm_cnt < duty_r);
         pwm_g <= (pwm_cnt < duty_g);
         pwm_b <= (pwm_cnt < duty_b);
      end
   end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: two instances (fast timebase with slow fade, and
// prescaled timebase with single-period fade) measured period by period.
module tb_rgb_pwm_fader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid0, valid1;
   logic [7:0] tgt_r, tgt_g, tgt_b;
   logic       fade_en;
   logic       ready0, ready1, busy0, busy1;
   logic [2:0] pwm0, pwm1;
   logic [1:0] dbg0, dbg1;

   int cyc;
   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   rgb_pwm_fader #(.CLK_DIV(1), .FADE_DIV(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .tgt_valid(valid0), .tgt_ready(ready0),
      .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b), .fade_en(fade_en),
      .pwm_r(pwm0[2]), .pwm_g(pwm0[1]), .pwm_b(pwm0[0]),
      .busy(busy0), .dbg_state(dbg0)
   );

   rgb_pwm_fader #(.CLK_DIV(3), .FADE_DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .tgt_valid(valid1), .tgt_ready(ready1),
      .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b), .fade_en(fade_en),
      .pwm_r(pwm1[2]), .pwm_g(pwm1[1]), .pwm_b(pwm1[0]),
      .busy(busy1), .dbg_state(dbg1)
   );

   // Clock edges since reset release; window m spans edges P*m+1 .. P*m+P.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected high-clock counts for one full PWM period, plus busy after the closing boundary.
   task automatic push_exp(input bit sel, input int r, input int g, input int b, input bit bz);
      int d;
      d = sel ? 3 : 1;
      exp_q.push_back({1'b0, bz, 10'(r * d), 10'(g * d), 10'(b * d)});
   endtask

   task automatic wait_mid(input bit sel);
      int p;
      p = sel ? 768 : 256;
      do begin @(posedge clk); #1; end while ((cyc % p) != p / 2);
   endtask

   task automatic run_windows(input bit sel, input int n);
      int p, cr, cg, cb;
      logic [2:0] pw;
      logic bz;
      logic [31:0] e;
      p = sel ? 768 : 256;
      for (int w = 0; w < n; w++) begin
         do begin @(posedge clk); #1; end while ((cyc % p) != 1);
         cr = 0; cg = 0; cb = 0;
         for (int i = 0; i < p; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            pw = sel ? pwm1 : pwm0;
            cr += int'(pw[2]); cg += int'(pw[1]); cb += int'(pw[0]);
         end
         bz = sel ? busy1 : busy0;
         if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq($sformatf("d%0d_w%0d_r", sel, w), 32'(cr), 32'(e[29:20]));
            check_eq($sformatf("d%0d_w%0d_g", sel, w), 32'(cg), 32'(e[19:10]));
            check_eq($sformatf("d%0d_w%0d_b", sel, w), 32'(cb), 32'(e[9:0]));
            check_eq($sformatf("d%0d_w%0d_busy", sel, w), 32'(bz), 32'(e[30]));
         end
      end
   endtask

   task automatic send(input bit sel, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input bit fe);
      int n;
      n = 0;
      @(negedge clk);
      tgt_r = r; tgt_g = g; tgt_b = b; fade_en = fe;
      if (sel) valid1 = 1'b1; else valid0 = 1'b1;
      while (!(sel ? ready1 : ready0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) check_eq("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      check_eq("accept_busy", 32'(sel ? busy1 : busy0), 32'd1);
      @(negedge clk);
      valid0 = 1'b0; valid1 = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
      tgt_r = 8'd0; tgt_g = 8'd0; tgt_b = 8'd0; fade_en = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_pwm0", 32'(pwm0), 32'd0);
      check_eq("rst_ready0", 32'(ready0), 32'd1);
      check_eq("rst_busy0", 32'(busy0), 32'd0);
      check_eq("rst_state0", 32'(dbg0), 32'd0);
      check_eq("rst_ready1", 32'(ready1), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      push_exp(0, 0, 0, 0, 0);
      run_windows(0, 1);

      // Snap, then a second snap accepted mid-period must not disturb that period.
      wait_mid(0);
      push_exp(0, 64, 0, 255, 0);
      send(0, 8'd64, 8'd0, 8'd255, 1'b0);
      run_windows(0, 1);
      wait_mid(0);
      push_exp(0, 64, 0, 255, 0);
      push_exp(0, 10, 20, 30, 0);
      fork
         run_windows(0, 1);
         begin
            do begin @(posedge clk); #1; end while ((cyc % 256) != 100);
            send(0, 8'd10, 8'd20, 8'd30, 1'b0);
         end
      join
      run_windows(0, 1);

      wait_mid(0);
      push_exp(0, 0, 0, 0, 0);
      send(0, 8'd0, 8'd0, 8'd0, 1'b0);
      run_windows(0, 1);

      // Fade up 0 -> 3 with two periods per step.
      wait_mid(0);
      push_exp(0, 0, 0, 0, 1); push_exp(0, 1, 0, 0, 1); push_exp(0, 1, 0, 0, 1);
      push_exp(0, 2, 0, 0, 1); push_exp(0, 2, 0, 0, 0); push_exp(0, 3, 0, 0, 0);
      send(0, 8'd3, 8'd0, 8'd0, 1'b1);
      check_eq("fade_state", 32'(dbg0), 32'd2);
      run_windows(0, 6);

      // Backpressure: r=200 held during a fade 3 -> 6, accepted as busy falls.
      wait_mid(0);
      push_exp(0, 3, 0, 0, 1); push_exp(0, 4, 0, 0, 1); push_exp(0, 4, 0, 0, 1);
      push_exp(0, 5, 0, 0, 1); push_exp(0, 5, 0, 0, 0); push_exp(0, 6, 0, 0, 1);
      push_exp(0, 6, 0, 0, 1); push_exp(0, 7, 0, 0, 1);
      send(0, 8'd6, 8'd0, 8'd0, 1'b1);
      tgt_r = 8'd200; fade_en = 1'b1; valid0 = 1'b1;
      fork
         run_windows(0, 8);
         begin
            repeat (20) @(negedge clk);
            check_eq("bp_ready_low", 32'(ready0), 32'd0);
            n = 0;
            while (!ready0 && n < 5000) begin
               @(negedge clk);
               n++;
            end
            if (n >= 5000) check_eq("bp_timeout", 32'd0, 32'd1);
            check_eq("bp_ready_phase", 32'(cyc % 256), 32'd0);
            @(posedge clk); #1;
            check_eq("bp_accept", 32'(busy0), 32'd1);
            @(negedge clk);
            valid0 = 1'b0;
         end
      join

      // Reset in the middle of the ramp toward 200 (duty 7 at this point).
      do begin @(posedge clk); #1; end while ((cyc % 256) != 3);
      check_eq("pre_reset_pwm_r", 32'(pwm0[2]), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_pwm0", 32'(pwm0), 32'd0);
      check_eq("mid_rst_ready0", 32'(ready0), 32'd1);
      check_eq("mid_rst_busy0", 32'(busy0), 32'd0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      push_exp(0, 0, 0, 0, 0);
      run_windows(0, 1);

      // Fade to a target equal to the current duties ends at the first step.
      wait_mid(0);
      push_exp(0, 0, 0, 0, 0);
      send(0, 8'd0, 8'd0, 8'd0, 1'b1);
      run_windows(0, 1);

      // Prescaled instance: duty 128 at CLK_DIV=3, then a bidirectional fade.
      wait_mid(1);
      push_exp(1, 128, 128, 128, 0);
      send(1, 8'd128, 8'd128, 8'd128, 1'b0);
      run_windows(1, 1);
      wait_mid(1);
      push_exp(1, 10, 0, 0, 0);
      send(1, 8'd10, 8'd0, 8'd0, 1'b0);
      run_windows(1, 1);
      wait_mid(1);
      push_exp(1, 9, 1, 0, 0);
      push_exp(1, 8, 2, 0, 0);
      send(1, 8'd8, 8'd2, 8'd0, 1'b1);
      run_windows(1, 2);

      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
